// File: rtl/axis_pkt_buffer_pkg.sv
// Shared types and helpers for the axis_pkt_buffer store-and-forward packet buffer.
package axis_pkt_buffer_pkg;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  // Pointer width carries one extra wrap bit so that full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_buffer_ram.sv
// Simple dual-port RAM for axis_pkt_buffer: one write port, one synchronous read port, no reset.
module axis_pkt_buffer_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_pkt_buffer.sv
// Store-and-forward AXI-Stream packet buffer: overflowing packets are dropped whole, never stalled.
// Statistics outputs are built only when AXIS_PKT_BUF_STATS_EN is defined; otherwise they are tied to 0.
module axis_pkt_buffer
  import axis_pkt_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  drop_pulse
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int RW = DATA_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

  wr_state_e     wr_state_q, wr_state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          s_ready_q;
  logic          s_hs_s, full_s, we_s, commit_s, drop_s;

  logic          readable_s, pop_s, rd_en_s;
  logic [1:0]    occ_s;
  logic          m_valid_q, m_valid_d, sk_valid_q, sk_valid_d, pend_q, pend_d;
  logic [RW-1:0] m_beat_q, m_beat_d, sk_beat_q, sk_beat_d, ram_rdata_s;

  assign s_axis_tready = s_ready_q;
  assign s_hs_s        = s_axis_tvalid & s_ready_q;
  // Full is judged against rd_ptr before any read in this same cycle.
  assign full_s        = ((wr_ptr_q - rd_ptr_q) == PTR_DEPTH);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= 1'b1;
    end
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    we_s        = 1'b0;
    commit_s    = 1'b0;
    drop_s      = 1'b0;
    case (wr_state_q)
      ST_ACCEPT: begin
        if (s_hs_s && !full_s) begin
          we_s     = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (s_axis_tlast) begin
            wr_commit_d = wr_ptr_q + PTR_ONE;
            commit_s    = 1'b1;
          end else begin
            wr_commit_d = wr_commit_q;
          end
        end else if (s_hs_s) begin
          // Rewind over the partial packet; the rest of it is discarded in DROP.
          wr_ptr_d = wr_commit_q;
          drop_s   = 1'b1;
          if (s_axis_tlast) begin
            wr_state_d = ST_ACCEPT;
          end else begin
            wr_state_d = ST_DROP;
          end
        end else begin
          wr_state_d = ST_ACCEPT;
        end
      end
      ST_DROP: begin
        if (s_hs_s && s_axis_tlast) begin
          wr_state_d = ST_ACCEPT;
        end else begin
          wr_state_d = ST_DROP;
        end
      end
      default: wr_state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q  <= ST_ACCEPT;
      wr_ptr_q    <= {PW{1'b0}};
      wr_commit_q <= {PW{1'b0}};
    end else begin
      wr_state_q  <= wr_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
    end
  end

  axis_pkt_buffer_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (ACLK),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .re_i    (rd_en_s),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata_s)
  );

  // Occupancy counts the read in flight, so a prefetch is issued only when a slot is guaranteed.
  assign readable_s = (rd_ptr_q != wr_commit_q);
  assign pop_s      = m_valid_q & m_axis_tready;
  assign occ_s      = {1'b0, m_valid_q} + {1'b0, sk_valid_q} + {1'b0, pend_q};
  assign rd_en_s    = readable_s && ((occ_s - {1'b0, pop_s}) < 2'd2);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    pend_d     = rd_en_s;
    m_valid_d  = m_valid_q;
    m_beat_d   = m_beat_q;
    sk_valid_d = sk_valid_q;
    sk_beat_d  = sk_beat_q;
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (!m_valid_q || pop_s) begin
      if (sk_valid_q) begin
        m_valid_d  = 1'b1;
        m_beat_d   = sk_beat_q;
        sk_valid_d = pend_q;
        sk_beat_d  = pend_q ? ram_rdata_s : sk_beat_q;
      end else begin
        m_valid_d  = pend_q;
        m_beat_d   = pend_q ? ram_rdata_s : m_beat_q;
      end
    end else begin
      if (pend_q) begin
        sk_valid_d = 1'b1;
        sk_beat_d  = ram_rdata_s;
      end else begin
        sk_valid_d = sk_valid_q;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ptr_q   <= {PW{1'b0}};
      pend_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_beat_q   <= {RW{1'b0}};
      sk_valid_q <= 1'b0;
      sk_beat_q  <= {RW{1'b0}};
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      m_valid_q  <= m_valid_d;
      m_beat_q   <= m_beat_d;
      sk_valid_q <= sk_valid_d;
      sk_beat_q  <= sk_beat_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_beat_q[DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_beat_q[DATA_WIDTH];

`ifdef AXIS_PKT_BUF_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q;
  logic                 drop_pulse_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_cnt_q    <= {CNT_WIDTH{1'b0}};
      drop_cnt_q   <= {CNT_WIDTH{1'b0}};
      drop_pulse_q <= 1'b0;
    end else begin
      if (commit_s) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
      end
      if (drop_s) begin
        drop_cnt_q <= drop_cnt_q + CNT_ONE;
      end
      drop_pulse_q <= drop_s;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = commit_s ^ drop_s;
  assign pkt_count      = {CNT_WIDTH{1'b0}};
  assign drop_count     = {CNT_WIDTH{1'b0}};
  assign drop_pulse     = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// Self-checking bench for axis_pkt_buffer: a DEPTH=16 instance for directed cases and a
// DEPTH=1024 instance for randomized traffic against a queue-based reference model.
module tb_axis_pkt_buffer;

  localparam int DW   = 32;
  localparam int NPKT = 400;
`ifdef AXIS_PKT_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [DW:0] beat_t;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESETN;

  logic [DW-1:0] a_s_tdata, a_m_tdata, b_s_tdata, b_m_tdata;
  logic a_s_tvalid, a_s_tlast, a_s_tready, a_m_tvalid, a_m_tlast, a_m_tready, a_pulse;
  logic b_s_tvalid, b_s_tlast, b_s_tready, b_m_tvalid, b_m_tlast, b_m_tready, b_pulse;
  logic [31:0] a_pkt, a_drop, b_pkt, b_drop;

  axis_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .CNT_WIDTH(32)) u_small (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tlast(a_s_tlast),
    .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
    .m_axis_tready(a_m_tready),
    .pkt_count(a_pkt), .drop_count(a_drop), .drop_pulse(a_pulse));

  axis_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(1024), .CNT_WIDTH(32)) u_big (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tlast(b_s_tlast),
    .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
    .m_axis_tready(b_m_tready),
    .pkt_count(b_pkt), .drop_count(b_drop), .drop_pulse(b_pulse));

  int checks, failures;
  beat_t a_out_q[$], b_out_q[$], b_exp_q[$];
  int a_pulse_cnt = 0, a_hold_err = 0, b_hold_err = 0, b_gap_err = 0;
  logic a_pv = 1'b0, a_pr = 1'b0, b_pv = 1'b0, b_pr = 1'b0, b_in_pkt = 1'b0;
  beat_t a_pb = '0, b_pb = '0;

  // Output monitors: record handshaken beats, hold-stability violations and intra-packet gaps.
  always @(negedge ACLK) begin
    if (a_m_tvalid && a_m_tready) a_out_q.push_back({a_m_tlast, a_m_tdata});
    if (a_pulse) a_pulse_cnt <= a_pulse_cnt + 1;
    if (a_pv && !a_pr && !(a_m_tvalid && ({a_m_tlast, a_m_tdata} == a_pb))) a_hold_err <= a_hold_err + 1;
    a_pv <= a_m_tvalid && ARESETN;
    a_pr <= a_m_tready;
    a_pb <= {a_m_tlast, a_m_tdata};
  end

  always @(negedge ACLK) begin
    if (b_m_tvalid && b_m_tready) b_out_q.push_back({b_m_tlast, b_m_tdata});
    if (b_pv && !b_pr && !(b_m_tvalid && ({b_m_tlast, b_m_tdata} == b_pb))) b_hold_err <= b_hold_err + 1;
    if (b_in_pkt && !b_m_tvalid) b_gap_err <= b_gap_err + 1;
    if (!ARESETN) b_in_pkt <= 1'b0;
    else if (b_m_tvalid && b_m_tready) b_in_pkt <= !b_m_tlast;
    b_pv <= b_m_tvalid && ARESETN;
    b_pr <= b_m_tready;
    b_pb <= {b_m_tlast, b_m_tdata};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (3) tick();
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic a_send(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      a_s_tdata  = base + DW'(i);
      a_s_tvalid = 1'b1;
      a_s_tlast  = (i == len - 1);
      tick();
    end
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
  endtask

  task automatic a_wait(input int n, input int budget);
    for (int c = 0; c < budget && a_out_q.size() < n; c++) tick();
  endtask

  task automatic a_chk_pkt(input string tag, input int n, input logic [DW-1:0] base);
    beat_t bt;
    chk({tag, "_len"}, a_out_q.size(), n);
    for (int i = 0; i < n && i < a_out_q.size(); i++) begin
      bt = a_out_q[i];
      chk({tag, "_data"}, bt[DW-1:0], base + DW'(i));
      chk({tag, "_last"}, bt[DW], (i == n - 1));
    end
  endtask

  initial begin
    int gate_to, sent, len, w;
    bit done;
    beat_t bt, be;
    checks = 0; failures = 0;
    ARESETN = 1'b0;
    a_s_tdata = '0; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b0;

    // Reset state.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_s_tready", a_s_tready, 0);
    chk("rst_m_tvalid", a_m_tvalid, 0);
    chk("rst_m_tdata", a_m_tdata, 0);
    chk("rst_m_tlast", a_m_tlast, 0);
    chk("rst_pkt", a_pkt, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_pulse", a_pulse, 0);
    ARESETN = 1'b1;
    #1;
    chk("rel_s_tready_low", a_s_tready, 0);
    @(negedge ACLK);
    chk("rel_s_tready_high", a_s_tready, 1);
    tick();

    // One 8-beat packet, data 1..8, with output latency.
    a_out_q.delete();
    a_send(8, 1);
    @(negedge ACLK); chk("lat_t0", a_m_tvalid, 0);
    @(negedge ACLK); chk("lat_t1", a_m_tvalid, 0);
    @(negedge ACLK); chk("lat_t2", a_m_tvalid, 1);
    chk("lat_t2_data", a_m_tdata, 1);
    #1;
    a_wait(8, 40);
    repeat (5) tick();
    a_chk_pkt("s1", 8, 1);
    chk("s1_pkt", a_pkt, 64'(STATS));
    chk("s1_drop", a_drop, 0);

    // 20-beat packet into DEPTH=16 is dropped; the following 4-beat packet passes.
    do_reset();
    a_out_q.delete();
    w = a_pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      a_s_tdata = 100 + i; a_s_tvalid = 1'b1; a_s_tlast = (i == 19);
      tick();
      if (i == 15) chk("s2_pulse_before", a_pulse, 0);
      if (i == 16) chk("s2_pulse_at", a_pulse, 64'(STATS));
      if (i == 17) chk("s2_pulse_after", a_pulse, 0);
    end
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    a_send(4, 200);
    a_wait(4, 60);
    repeat (20) tick();
    a_chk_pkt("s2", 4, 200);
    chk("s2_drop", a_drop, 64'(STATS));
    chk("s2_pkt", a_pkt, 64'(STATS));
    chk("s2_pulse_cnt", a_pulse_cnt - w, 64'(STATS));

    // Two back-to-back 10-beat packets with the consumer stalled: second is dropped.
    do_reset();
    a_out_q.delete();
    a_m_tready = 1'b0;
    a_send(10, 300);
    a_send(10, 400);
    repeat (5) tick();
    chk("s3_stalled_out", a_out_q.size(), 0);
    chk("s3_stalled_valid", a_m_tvalid, 1);
    chk("s3_stalled_data", a_m_tdata, 300);
    a_m_tready = 1'b1;
    a_wait(10, 60);
    repeat (30) tick();
    a_chk_pkt("s3", 10, 300);
    chk("s3_pkt", a_pkt, 64'(STATS));
    chk("s3_drop", a_drop, 64'(STATS));

    // Reset after beat 3 of a 6-beat packet leaves nothing behind.
    do_reset();
    a_out_q.delete();
    for (int i = 0; i < 3; i++) begin
      a_s_tdata = 600 + i; a_s_tvalid = 1'b1; a_s_tlast = 1'b0;
      tick();
    end
    a_s_tvalid = 1'b0;
    ARESETN = 1'b0;
    tick(); tick();
    @(negedge ACLK);
    chk("s5_rst_tready", a_s_tready, 0);
    ARESETN = 1'b1;
    w = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (a_m_tvalid) w++;
    end
    #1;
    chk("s5_valid_seen", w, 0);
    chk("s5_out", a_out_q.size(), 0);
    chk("s5_pkt", a_pkt, 0);
    chk("s5_drop", a_drop, 0);
    a_send(5, 700);
    a_wait(5, 40);
    repeat (10) tick();
    a_chk_pkt("s5_next", 5, 700);
    chk("a_hold", a_hold_err, 0);

    // Randomized traffic on DEPTH=1024 with a 50% consumer; inputs are paced so nothing overflows.
    do_reset();
    b_out_q.delete();
    b_exp_q.delete();
    gate_to = 0; sent = 0; done = 1'b0;
    fork
      begin
        for (int p = 0; p < NPKT; p++) begin
          len = $urandom_range(1, 64);
          w = 0;
          while ((sent - b_out_q.size() + len > 1024) && w < 4000) begin tick(); w++; end
          if (w >= 4000) gate_to++;
          for (int i = 0; i < len; i++) begin
            bt = {(i == len - 1), DW'($urandom)};
            b_exp_q.push_back(bt);
            b_s_tdata = bt[DW-1:0]; b_s_tlast = bt[DW]; b_s_tvalid = 1'b1;
            sent++;
            tick();
          end
          b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          b_m_tready = ($urandom_range(0, 1) == 1);
          tick();
        end
        b_m_tready = 1'b1;
      end
    join
    for (int c = 0; c < 5000 && b_out_q.size() < b_exp_q.size(); c++) tick();
    repeat (10) tick();
    chk("rand_gate_timeout", gate_to, 0);
    chk("rand_len", b_out_q.size(), b_exp_q.size());
    for (int i = 0; i < b_exp_q.size() && i < b_out_q.size(); i++) begin
      bt = b_out_q[i];
      be = b_exp_q[i];
      chk("rand_beat", bt, be);
    end
    chk("rand_pkt", b_pkt, STATS ? 64'(NPKT) : 64'd0);
    chk("rand_drop", b_drop, 0);
    chk("rand_gap", b_gap_err, 0);
    chk("rand_hold", b_hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
